// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM frame scheduler: phase encoding and default symbol geometry.
package ofdm_pkg;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_PREAMBLE = 3'd1,
        PH_CP       = 3'd2,
        PH_DATA     = 3'd3,
        PH_GUARD    = 3'd4
    } phase_e;

    localparam int DEF_FFT_SIZE = 1024;
    localparam int DEF_CP_LEN   = 256;

endpackage

// File: rtl/ofdm_phase_counter.sv
// Sample counter for one frame phase: clears on load, advances per step, wraps to zero on its terminal count.
module ofdm_phase_counter #(
    parameter int WIDTH = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Terminal-count compare and next count; count_next is exported so the address mux tracks the counter exactly.
    always_comb begin
        tc = (count_r == last_val);
        if (clear) begin
            count_next = '0;
        end else if (step) begin
            if (tc) begin
                count_next = '0;
            end else begin
                count_next = count_r + WIDTH'(1);
            end
        end else begin
            count_next = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_next;
        end
    end

endmodule

// File: rtl/ofdm_frame_scheduler.sv
// OFDM transmit frame sequencer: PREAMBLE, SYMS_PER_FRAME x (CP + FFT body), GUARD.
// Drives the IFFT buffer read address and the output mux phase select; all outputs registered.
module ofdm_frame_scheduler
    import ofdm_pkg::*;
#(
    parameter int COUNT_SIZE     = 12,
    parameter int FFT_SIZE       = DEF_FFT_SIZE,
    parameter int CP_LEN         = DEF_CP_LEN,
    parameter int PREAMBLE_LEN   = 2560,
    parameter int GUARD_LEN      = 64,
    parameter int SYMS_PER_FRAME = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ready_in,
    input  logic                  start,
    input  logic                  continuous,
    output logic [2:0]            phase,
    output logic [COUNT_SIZE-1:0] rd_addr,
    output logic [7:0]            symbol_idx,
    output logic                  frame_start,
    output logic                  symbol_start,
    output logic                  frame_done,
    output logic                  busy
);

    // One extra bit so the preamble length can exceed the address range.
    localparam int CW = COUNT_SIZE + 1;

    localparam logic [CW-1:0] PRE_LAST_C   = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] CP_LAST_C    = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] FFT_LAST_C   = CW'(FFT_SIZE - 1);
    localparam logic [CW-1:0] GUARD_LAST_C = CW'(GUARD_LEN - 1);
    localparam logic [CW-1:0] CP_BASE_C    = CW'(FFT_SIZE - CP_LEN);
    localparam logic [7:0]    SYM_LAST_C   = 8'(SYMS_PER_FRAME - 1);

    phase_e                  state_r;
    phase_e                  state_nx_s;
    logic [7:0]              sym_r;
    logic [7:0]              sym_nx_s;
    logic [COUNT_SIZE-1:0]   rd_addr_r;
    logic [COUNT_SIZE-1:0]   rd_addr_nx_s;
    logic                    frame_start_r;
    logic                    frame_start_nx_s;
    logic                    symbol_start_r;
    logic                    symbol_start_nx_s;
    logic                    frame_done_r;
    logic                    frame_done_nx_s;
    logic                    busy_r;
    logic                    busy_nx_s;
    logic                    step_s;
    logic                    cnt_clear_s;
    logic                    cnt_step_s;
    logic                    cnt_tc_s;
    logic [CW-1:0]           cnt_last_s;
    logic [CW-1:0]           cnt_nx_s;

    assign step_s = enable && ready_in;

    ofdm_phase_counter #(
        .WIDTH (CW)
    ) u_phase_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear_s),
        .step       (cnt_step_s),
        .last_val   (cnt_last_s),
        .count_next (cnt_nx_s),
        .tc         (cnt_tc_s)
    );

    // Phase sequencing, symbol counting, pulse generation and next read address.
    always_comb begin
        state_nx_s        = state_r;
        sym_nx_s          = sym_r;
        frame_start_nx_s  = 1'b0;
        symbol_start_nx_s = 1'b0;
        frame_done_nx_s   = 1'b0;
        cnt_clear_s       = 1'b0;
        cnt_step_s        = 1'b0;
        cnt_last_s        = '0;

        case (state_r)
            PH_IDLE: begin
                cnt_clear_s = 1'b1;
                sym_nx_s    = 8'd0;
                if (start) begin
                    state_nx_s       = PH_PREAMBLE;
                    frame_start_nx_s = 1'b1;
                end else begin
                    state_nx_s = PH_IDLE;
                end
            end
            PH_PREAMBLE: begin
                cnt_last_s = PRE_LAST_C;
                cnt_step_s = step_s;
                if (step_s && cnt_tc_s) begin
                    state_nx_s        = PH_CP;
                    symbol_start_nx_s = 1'b1;
                end else begin
                    state_nx_s = PH_PREAMBLE;
                end
            end
            PH_CP: begin
                cnt_last_s = CP_LAST_C;
                cnt_step_s = step_s;
                if (step_s && cnt_tc_s) begin
                    state_nx_s = PH_DATA;
                end else begin
                    state_nx_s = PH_CP;
                end
            end
            PH_DATA: begin
                cnt_last_s = FFT_LAST_C;
                cnt_step_s = step_s;
                if (step_s && cnt_tc_s) begin
                    if (sym_r < SYM_LAST_C) begin
                        state_nx_s        = PH_CP;
                        sym_nx_s          = sym_r + 8'd1;
                        symbol_start_nx_s = 1'b1;
                    end else begin
                        state_nx_s = PH_GUARD;
                        sym_nx_s   = 8'd0;
                    end
                end else begin
                    state_nx_s = PH_DATA;
                end
            end
            PH_GUARD: begin
                cnt_last_s = GUARD_LAST_C;
                cnt_step_s = step_s;
                if (step_s && cnt_tc_s) begin
                    frame_done_nx_s = 1'b1;
                    if (continuous) begin
                        state_nx_s       = PH_PREAMBLE;
                        frame_start_nx_s = 1'b1;
                    end else begin
                        state_nx_s = PH_IDLE;
                    end
                end else begin
                    state_nx_s = PH_GUARD;
                end
            end
            default: begin
                state_nx_s  = PH_IDLE;
                sym_nx_s    = 8'd0;
                cnt_clear_s = 1'b1;
            end
        endcase

        // Address follows the phase/count pair that will be registered this edge.
        case (state_nx_s)
            PH_CP:   rd_addr_nx_s = COUNT_SIZE'(CP_BASE_C + cnt_nx_s);
            PH_DATA: rd_addr_nx_s = COUNT_SIZE'(cnt_nx_s);
            default: rd_addr_nx_s = '0;
        endcase

        busy_nx_s = (state_nx_s != PH_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= PH_IDLE;
            sym_r          <= 8'd0;
            rd_addr_r      <= '0;
            frame_start_r  <= 1'b0;
            symbol_start_r <= 1'b0;
            frame_done_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            sym_r          <= sym_nx_s;
            rd_addr_r      <= rd_addr_nx_s;
            frame_start_r  <= frame_start_nx_s;
            symbol_start_r <= symbol_start_nx_s;
            frame_done_r   <= frame_done_nx_s;
            busy_r         <= busy_nx_s;
        end
    end

    assign phase        = state_r;
    assign rd_addr      = rd_addr_r;
    assign symbol_idx   = sym_r;
    assign frame_start  = frame_start_r;
    assign symbol_start = symbol_start_r;
    assign frame_done   = frame_done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
// Self-checking bench for ofdm_frame_scheduler: frame-position reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized soak.
module tb_ofdm_frame_scheduler;

    localparam int CS        = 4;
    localparam int FFT       = 8;
    localparam int CPL       = 2;
    localparam int PRE       = 4;
    localparam int GRD       = 3;
    localparam int SYMS      = 2;
    localparam int SYM_LEN   = CPL + FFT;
    localparam int DATA_END  = PRE + SYMS * SYM_LEN;
    localparam int FRAME_LEN = DATA_END + GRD;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          ready_in;
    logic          start;
    logic          continuous;
    logic [2:0]    phase;
    logic [CS-1:0] rd_addr;
    logic [7:0]    symbol_idx;
    logic          frame_start;
    logic          symbol_start;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    ofdm_frame_scheduler #(
        .COUNT_SIZE     (CS),
        .FFT_SIZE       (FFT),
        .CP_LEN         (CPL),
        .PREAMBLE_LEN   (PRE),
        .GUARD_LEN      (GRD),
        .SYMS_PER_FRAME (SYMS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .ready_in     (ready_in),
        .start        (start),
        .continuous   (continuous),
        .phase        (phase),
        .rd_addr      (rd_addr),
        .symbol_idx   (symbol_idx),
        .frame_start  (frame_start),
        .symbol_start (symbol_start),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Reference model: a frame is just a position 0..FRAME_LEN-1 advanced by accepted steps.
    typedef struct packed {
        logic        busy;
        logic [15:0] pos;
        logic        fs;
        logic        ss;
        logic        fd;
    } mstate_t;

    mstate_t m_st;

    function automatic bit is_cp_first(input int p);
        return (p >= PRE) && (p < DATA_END) && (((p - PRE) % SYM_LEN) == 0);
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit st, input bit cont, input bit stp);
        mstate_t n;
        n    = s;
        n.fs = 1'b0;
        n.ss = 1'b0;
        n.fd = 1'b0;
        if (!s.busy) begin
            if (st) begin
                n.busy = 1'b1;
                n.pos  = 16'd0;
                n.fs   = 1'b1;
            end
        end else if (stp) begin
            if (int'(s.pos) == FRAME_LEN - 1) begin
                n.fd  = 1'b1;
                n.pos = 16'd0;
                if (cont) n.fs = 1'b1;
                else      n.busy = 1'b0;
            end else begin
                n.pos = s.pos + 16'd1;
                n.ss  = is_cp_first(int'(n.pos));
            end
        end
        return n;
    endfunction

    function automatic void expect_of(input mstate_t s, output int ph, output int addr, output int sym);
        int p;
        int off;
        int w;
        p    = int'(s.pos);
        ph   = 0;
        addr = 0;
        sym  = 0;
        if (s.busy) begin
            if (p < PRE) begin
                ph = 1;
            end else if (p < DATA_END) begin
                off = p - PRE;
                sym = off / SYM_LEN;
                w   = off % SYM_LEN;
                if (w < CPL) begin
                    ph   = 2;
                    addr = FFT - CPL + w;
                end else begin
                    ph   = 3;
                    addr = w - CPL;
                end
            end else begin
                ph = 4;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edges as the design.
    always @(posedge clock or negedge reset) begin
        if (!reset) m_st <= '0;
        else        m_st <= model_next(m_st, start, continuous, enable && ready_in);
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clock) begin : cmp
        int eph;
        int ea;
        int es;
        if (cmp_on) begin
            expect_of(m_st, eph, ea, es);
            check("phase", int'(phase), eph);
            check("rd_addr", int'(rd_addr), ea);
            check("symbol_idx", int'(symbol_idx), es);
            check("busy", int'(busy), int'(m_st.busy));
            check("frame_start", int'(frame_start), int'(m_st.fs));
            check("symbol_start", int'(symbol_start), int'(m_st.ss));
            check("frame_done", int'(frame_done), int'(m_st.fd));
        end
    end

    // Starts one frame from IDLE at a negedge; measures cycles from frame_start to frame_done.
    task automatic run_frame(input bit toggle, output int gap, output int ss_cnt,
                             output int ss2_sym, output int cp_addr);
        start    = 1'b1;
        ready_in = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (toggle) ready_in = 1'b0;
        check("first_frame_start", int'(frame_start), 1);
        check("first_phase", int'(phase), 1);
        gap     = 0;
        ss_cnt  = 0;
        ss2_sym = -1;
        cp_addr = -1;
        while (!frame_done && gap < 400) begin
            @(negedge clock);
            gap++;
            if (toggle) ready_in = ~ready_in;
            if (symbol_start) begin
                ss_cnt++;
                if (ss_cnt == 1) cp_addr = int'(rd_addr);
                if (ss_cnt == 2) ss2_sym = int'(symbol_idx);
            end
        end
        if (!frame_done) check("frame_done_timeout", 0, 1);
        ready_in = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (phase != 3'd0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", int'(phase), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int ssn;
        int ss2;
        int cpa;
        int n;

        reset      = 1'b0;
        enable     = 1'b0;
        ready_in   = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_phase", int'(phase), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        @(negedge clock);
        reset    = 1'b1;
        cmp_on   = 1'b1;
        enable   = 1'b1;
        ready_in = 1'b1;

        // Idle with no start request.
        repeat (50) @(negedge clock);
        check("idle50_phase", int'(phase), 0);
        check("idle50_busy", int'(busy), 0);

        // Single frame, step every cycle.
        run_frame(1'b0, gap, ssn, ss2, cpa);
        check("frame_steps", gap, 27);
        check("symbol_start_count", ssn, 2);
        check("second_symbol_idx", ss2, 1);
        check("first_cp_addr", cpa, 6);
        check("after_frame_phase", int'(phase), 0);
        repeat (3) @(negedge clock);

        // Continuous: back-to-back frames without an IDLE gap.
        continuous = 1'b1;
        run_frame(1'b0, gap, ssn, ss2, cpa);
        check("cont_gap", gap, 27);
        check("cont_frame_start", int'(frame_start), 1);
        check("cont_phase", int'(phase), 1);
        continuous = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 400);
        check("cont_second_gap", n, 27);
        check("cont_end_phase", int'(phase), 0);
        repeat (2) @(negedge clock);

        // ready_in toggling: one step every second cycle.
        run_frame(1'b1, gap, ssn, ss2, cpa);
        check("toggle_gap", gap, 54);
        check("toggle_ss_count", ssn, 2);
        repeat (2) @(negedge clock);

        // enable held low mid-DATA.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(phase == 3'd3 && rd_addr == 4'd5) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reach_data5", int'(rd_addr), 5);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_rd_addr", int'(rd_addr), 5);
            check("hold_phase", int'(phase), 3);
        end
        enable = 1'b1;
        @(negedge clock);
        check("resume_rd_addr", int'(rd_addr), 6);
        wait_idle(100);
        repeat (2) @(negedge clock);

        // Reset during CP of symbol 1.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(phase == 3'd2 && symbol_idx == 8'd1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reach_cp_sym1", int'(symbol_idx), 1);
        #2 reset = 1'b0;
        #1;
        check("midreset_phase", int'(phase), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_rd_addr", int'(rd_addr), 0);
        check("midreset_symbol_idx", int'(symbol_idx), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        run_frame(1'b0, gap, ssn, ss2, cpa);
        check("post_reset_gap", gap, 27);
        repeat (2) @(negedge clock);

        // Randomized soak against the model, with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            enable     = ($urandom_range(0, 3) != 0);
            ready_in   = ($urandom_range(0, 2) != 0);
            start      = ($urandom_range(0, 7) == 0);
            continuous = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(negedge clock);
                #2 reset = 1'b1;
            end
        end
        @(negedge clock);
        enable     = 1'b1;
        ready_in   = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        wait_idle(200);
        repeat (2) @(negedge clock);
        cmp_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
